// File: rtl/four_adder_sub.sv
// Registered ripple-carry adder/subtractor; Cin selects subtract and feeds carry-in. Latency 1 cycle.
// No backpressure: one result per in_valid cycle, outputs hold while in_valid is low.
module four_adder_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] tmp,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] So,
  output logic             Cout,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] so_q, so_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  assign c[0] = Cin;

  // Inverting tmp and injecting Cin as carry gives A - tmp in two's complement.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign b[i]   = tmp[i] ^ Cin;
    assign s[i]   = A[i] ^ b[i] ^ c[i];
    assign c[i+1] = (A[i] & b[i]) | (A[i] & c[i]) | (b[i] & c[i]);
  end

  always_comb begin
    so_d   = so_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    vld_d  = 1'b0;
    if (in_valid) begin
      so_d   = s;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      so_q   <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      so_q   <= so_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign So        = so_q;
  assign Cout      = cout_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_four_adder_sub.sv
// Self-checking bench for four_adder_sub: directed corner cases plus random traffic against an arithmetic model.
module tb_four_adder_sub;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] tmp;
  logic       Cin;
  logic       in_valid;
  logic [3:0] So;
  logic       Cout;
  logic       overflow;
  logic       out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp_so;
  logic       exp_cout;
  logic       exp_ovf;

  four_adder_sub #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .tmp      (tmp),
    .Cin      (Cin),
    .in_valid (in_valid),
    .So       (So),
    .Cout     (Cout),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer add/sub in both unsigned and signed views.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] t, input logic c);
    int ua, ut, sa, st, ru, rs;
    logic co, ov;
    logic [3:0] r;
    ua = int'(a);
    ut = int'(t);
    sa = int'($signed(a));
    st = int'($signed(t));
    if (!c) begin
      ru = ua + ut;
      rs = sa + st;
      co = (ru > 15);
    end else begin
      ru = ua - ut;
      rs = sa - st;
      co = (ua >= ut);
    end
    r  = 4'(ru & 15);
    ov = (rs < -8) || (rs > 7);
    return {ov, co, r};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_vld);
    chk({tag, ".So"}, So, exp_so);
    chk({tag, ".Cout"}, {3'b0, Cout}, {3'b0, exp_cout});
    chk({tag, ".ovf"}, {3'b0, overflow}, {3'b0, exp_ovf});
    chk({tag, ".vld"}, {3'b0, out_valid}, {3'b0, exp_vld});
  endtask

  // Drive one cycle of stimulus at negedge, then check just after the capturing edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [3:0] a, input logic [3:0] t, input logic c);
    logic [5:0] m;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A        = a;
    tmp      = t;
    Cin      = c;
    if (r) begin
      exp_so = 4'd0; exp_cout = 1'b0; exp_ovf = 1'b0;
    end else if (v) begin
      m = model(a, t, c);
      exp_so = m[3:0]; exp_cout = m[4]; exp_ovf = m[5];
    end
    @(posedge clk);
    #1;
    check_all(tag, !r && v);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; tmp = '0; Cin = 1'b0;
    exp_so = 4'd0; exp_cout = 1'b0; exp_ovf = 1'b0;

    step("rst0", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("rst1", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("idle", 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

    step("add2+1",   1'b0, 1'b1, 4'b0010, 4'b0001, 1'b0);
    step("sub10-1",  1'b0, 1'b1, 4'b1010, 4'b0001, 1'b1);
    step("ovf_add",  1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
    step("ovf_sub",  1'b0, 1'b1, 4'b1000, 4'b0001, 1'b1);
    step("borrow",   1'b0, 1'b1, 4'b0000, 4'b0001, 1'b1);
    step("carry",    1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);

    // Explicit known values for a few corners, independent of the model.
    chk("carry.lit.So", So, 4'b0000);
    step("sub_zero", 1'b0, 1'b1, 4'b0101, 4'b0000, 1'b1);
    chk("sub_zero.lit.Cout", {3'b0, Cout}, 4'b0001);

    step("b2b0", 1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0);
    step("b2b1", 1'b0, 1'b1, 4'b0100, 4'b0110, 1'b1);
    step("b2b2", 1'b0, 1'b1, 4'b1001, 4'b1010, 1'b0);

    step("hold0", 1'b0, 1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
    step("hold1", 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1);

    step("pre_rst",  1'b0, 1'b1, 4'b0110, 4'b0101, 1'b0);
    step("rst_vld",  1'b1, 1'b1, 4'b0111, 4'b0111, 1'b0);
    step("post_rst", 1'b0, 1'b0, 4'b0111, 4'b0111, 1'b0);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
